apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Round-robin arbiter plus APB master sequencer that shares one APB bus among NUM_REQ requesters.
- Each requester hands over a single-beat read or write. The block drives the APB SETUP/ACCESS sequence, waits for PREADY and returns PRDATA/PSLVERR to the owning requester.
- A wait-state watchdog ends a hung transfer with an error.
- Sits between on-chip command sources (DMA, CPU bridge, test sequencer) and the shared APB slave interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; PSTRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before forced termination (>=2).

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  packed write strobes.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid with rsp_valid.
- rsp_slverr  out  1  error flag, shared; valid with rsp_valid.
- rsp_timeout  out  1  set with rsp_slverr when the watchdog ended the transfer.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first. Watchdog count = 0.
- Reset asserted mid-transfer: PSEL/PENABLE drop asynchronously. The in-flight transfer is abandoned with no rsp_valid.

FSM:
- IDLE:
  - If any req_valid, grant the first set bit searching from last_grant+1 with wrap-around.
  - Pulse req_ready[g] this cycle.
  - Latch addr/wdata/write/strb of g into transfer registers; update last_grant = g; go to SETUP.
  - With no req_valid, stay in IDLE with PSEL=0.
- SETUP:
  - PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA/PSTRB from latched registers.
  - Always go to ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1; all address/control/data held stable.
  - PREADY=1: capture PRDATA (reads; 0 on writes), PSLVERR, rsp_timeout=0. Go to DONE.
  - PREADY=0: increment the watchdog. When the count reaches TIMEOUT_CYCLES, go to DONE with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- DONE:
  - PSEL=0, PENABLE=0.
  - rsp_valid[g]=1 for exactly this cycle with rsp_rdata, rsp_slverr, rsp_timeout. Clear the watchdog; go to IDLE.

Rules:
- Latency: request accepted at cycle T; SETUP at T+1; ACCESS at T+2; with zero wait states rsp_valid at T+3; next grant earliest at T+4.
- Each wait state adds one cycle.
- PSTRB is forced to 0 for reads.
- Requester contract: hold req_valid and fields stable until req_ready. The block samples fields only in the grant cycle.
- Requester contract: a requester must not reissue before its rsp_valid. The block does not check this.
- A requester that drops req_valid before grant is simply not granted.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req_valid asserted and are served in round-robin order, so no requester waits more than NUM_REQ-1 transfers.
- PSLVERR is sampled only when PREADY=1 in ACCESS.
- Watchdog counter width is clog2(TIMEOUT_CYCLES+1). It counts only ACCESS cycles with PREADY=0.
- Timeout at the same edge PREADY rises: PREADY wins, normal completion.
- PADDR/PWDATA/PSTRB/PWRITE hold their last values in IDLE/DONE; PSEL=0 marks them don't-care.

Test Plan:
- Single write, NUM_REQ=2: req 0 writes addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, slave PREADY=1 in ACCESS -> req_ready[0] at T, PSEL at T+1, PENABLE at T+2, rsp_valid=2'b01 at T+3, rsp_slverr=0.
- Read with 3 wait states: req 1 reads 0x0000_0020, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles with stable PADDR; PSTRB=0; rsp_valid=2'b10 and rsp_rdata=0x1234_5678 at T+6.
- Contention: both requesters hold req_valid from reset for 4 transfers -> grant order 0,1,0,1; each req_ready one-hot; no back-to-back PSEL without an IDLE cycle.
- Slave error: PREADY=1 with PSLVERR=1 on a read -> rsp_slverr=1, rsp_timeout=0, the originating requester's rsp_valid bit set.
- Timeout: TIMEOUT_CYCLES=16, PREADY held low -> after 16 ACCESS cycles PSEL/PENABLE drop, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; the next pending request is then granted.
- Reset mid-ACCESS: RESETn low during a wait state -> PSEL/PENABLE/rsp_valid 0 immediately; after release requester 0 has priority and no stale rsp_valid is seen.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter in front of a single-beat APB master.
// Shares one APB bus among NUM_REQ requesters and runs the SETUP/ACCESS sequence.
// A wait-state watchdog ends a hung transfer with an error.
// Ports:
//   PCLK, RESETn                   clock, async active-low reset
//   req_valid/write/addr/wdata/strb packed per-requester commands (slice i = requester i)
//   req_ready                      one-hot accept, combinational in the grant cycle
//   rsp_valid                      one-hot one-cycle completion pulse
//   rsp_rdata/slverr/timeout       shared response fields, valid with rsp_valid
//   PADDR..PENABLE                 APB master outputs
//   PRDATA, PREADY, PSLVERR        APB slave returns
module apb_master_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             RESETn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_slverr,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PWRITE,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic                             PSEL,
  output logic                             PENABLE,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic [WD_W-1:0]  wd_cnt;
  logic [WD_W-1:0]  wd_nxt;

  // Round-robin search starting just after the last granted requester.
  // Gated by RESETn so req_ready stays low while reset is held.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vld = grant_vld & RESETn;
  end

  // Next-state, accept pulse and watchdog update.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    wd_nxt    = wd_cnt;
    case (state)
      S_IDLE: begin
        if (grant_vld && state == S_IDLE) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = S_SETUP;
        end
      end
      S_SETUP: state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          state_nxt = S_DONE;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
          if (wd_nxt == WD_W'(TIMEOUT_CYCLES)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        wd_nxt    = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered APB and response outputs.
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      wd_cnt      <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSTRB       <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd_cnt    <= wd_nxt;
      PSEL      <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
      PENABLE   <= (state_nxt == S_ACCESS);
      rsp_valid <= '0;

      if (state == S_IDLE && grant_vld) begin
        last_grant <= grant_idx;
        owner      <= grant_idx;
        PADDR      <= req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        PWDATA     <= req_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        PWRITE     <= req_write[grant_idx];
        // Reads never present strobes on the bus.
        PSTRB      <= req_write[grant_idx] ? req_strb[32'(grant_idx)*STRB_W +: STRB_W]
                                           : STRB_W'(0);
      end

      // Completion: PREADY takes precedence over a watchdog expiring on the same edge.
      if (state == S_ACCESS && state_nxt == S_DONE) begin
        rsp_valid[owner] <= 1'b1;
        if (PREADY) begin
          rsp_rdata   <= PWRITE ? DATA_WIDTH'(0) : PRDATA;
          rsp_slverr  <= PSLVERR;
          rsp_timeout <= 1'b0;
        end else begin
          rsp_rdata   <= '0;
          rsp_slverr  <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
